// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath muxes it drives.
// State enum, opcode/funct constants, selector encodings and the control word struct.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RST      = 5'd0,
        ST_FETCH0   = 5'd1,
        ST_FETCH1   = 5'd2,
        ST_DECODE   = 5'd3,
        ST_EXEC_R   = 5'd4,
        ST_WB_R     = 5'd5,
        ST_EXEC_I   = 5'd6,
        ST_WB_I     = 5'd7,
        ST_MEM_ADDR = 5'd8,
        ST_MEM_RD   = 5'd9,
        ST_MEM_WAIT = 5'd10,
        ST_MEM_WB   = 5'd11,
        ST_MEM_WR   = 5'd12,
        ST_BRANCH   = 5'd13,
        ST_JUMP     = 5'd14,
        ST_EXC      = 5'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALU1_PC   = 2'b00;
    localparam logic [1:0] ALU1_A    = 2'b01;
    localparam logic [1:0] ALU1_ZERO = 2'b10;
    localparam logic [1:0] ALU1_AUX  = 2'b11;

    localparam logic [1:0] ALU2_B       = 2'b00;
    localparam logic [1:0] ALU2_FOUR    = 2'b01;
    localparam logic [1:0] ALU2_IMM     = 2'b10;
    localparam logic [1:0] ALU2_IMM_SH2 = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef struct packed {
        logic [1:0] alu1_sel;
        logic [1:0] alu2_sel;
        logic [2:0] alu_op;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       epc_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct decoder: ALU operation, illegal-funct flag, and whether the op can overflow.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic       ovf_check
);

    always_comb begin
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        ovf_check = 1'b0;
        case (funct)
            FN_ADD: begin
                alu_op    = ALU_ADD;
                ovf_check = 1'b1;
            end
            FN_SUB: begin
                alu_op    = ALU_SUB;
                ovf_check = 1'b1;
            end
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every operand selector and write enable of the datapath.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [1:0] ALU1Selector,
    output logic [1:0] ALU2Selector,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] PCSource,
    output logic [4:0] state_dbg
);

    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl;
    logic [2:0] r_alu_op;
    logic       r_illegal;
    logic       r_ovf_check;

    // The vector itself is muxed in by the datapath when PCSource selects it.
    logic exc_vector_unused;
    assign exc_vector_unused = ^EXC_VECTOR;

    mc_alu_decode u_alu_decode (
        .funct     (funct),
        .alu_op    (r_alu_op),
        .illegal   (r_illegal),
        .ovf_check (r_ovf_check)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH0;
            end
            ST_FETCH0: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu1_sel  = ALU1_PC;
                ctrl.alu2_sel  = ALU2_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                state_d        = ST_FETCH1;
            end
            ST_FETCH1: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                state_d       = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ctrl.alu1_sel = ALU1_PC;
                ctrl.alu2_sel = ALU2_IMM_SH2;
                ctrl.alu_op   = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_EXC;
                endcase
            end
            ST_EXEC_R: begin
                ctrl.alu1_sel = ALU1_A;
                ctrl.alu2_sel = ALU2_B;
                ctrl.alu_op   = r_alu_op;
                if (r_illegal || (overflow && r_ovf_check)) begin
                    state_d = ST_EXC;
                end else begin
                    state_d = ST_WB_R;
                end
            end
            ST_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH0;
            end
            ST_EXEC_I: begin
                ctrl.alu1_sel = ALU1_A;
                ctrl.alu2_sel = ALU2_IMM;
                ctrl.alu_op   = ALU_ADD;
                state_d       = overflow ? ST_EXC : ST_WB_I;
            end
            ST_WB_I: begin
                ctrl.reg_write = 1'b1;
                state_d        = ST_FETCH0;
            end
            ST_MEM_ADDR: begin
                ctrl.alu1_sel = ALU1_A;
                ctrl.alu2_sel = ALU2_IMM;
                ctrl.alu_op   = ALU_ADD;
                state_d       = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                state_d       = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                ctrl.mem_read = 1'b1;
                state_d       = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                state_d         = ST_FETCH0;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                state_d        = ST_FETCH0;
            end
            ST_BRANCH: begin
                // The compare happens this cycle, so PCWrite follows zero directly.
                ctrl.alu1_sel  = ALU1_A;
                ctrl.alu2_sel  = ALU2_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = zero;
                state_d        = ST_FETCH0;
            end
            ST_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
                state_d        = ST_FETCH0;
            end
            ST_EXC: begin
                // PC was already advanced by 4 in FETCH0; PC-4 goes to EPC.
                ctrl.alu1_sel  = ALU1_PC;
                ctrl.alu2_sel  = ALU2_FOUR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
                ctrl.pc_source = PCSRC_EXC;
                ctrl.pc_write  = 1'b1;
                state_d        = ST_FETCH0;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign ALU1Selector = ctrl.alu1_sel;
    assign ALU2Selector = ctrl.alu2_sel;
    assign ALUOp        = ctrl.alu_op;
    assign PCWrite      = ctrl.pc_write;
    assign IRWrite      = ctrl.ir_write;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign RegWrite     = ctrl.reg_write;
    assign EPCWrite     = ctrl.epc_write;
    assign RegDst       = ctrl.reg_dst;
    assign MemToReg     = ctrl.mem_to_reg;
    assign PCSource     = ctrl.pc_source;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction traces compared against
// an instruction-level reference model.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [1:0] ALU1Selector, ALU2Selector, PCSource;
    logic [2:0] ALUOp;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, EPCWrite, RegDst, MemToReg;
    logic [4:0] state_dbg;

    int checks = 0;
    int failures = 0;

    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];
    logic [21:0] got, want;

    mc_control_fsm #(.EXC_VECTOR(32'h0000_00FF)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .overflow     (overflow),
        .ALU1Selector (ALU1Selector),
        .ALU2Selector (ALU2Selector),
        .ALUOp        (ALUOp),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .EPCWrite     (EPCWrite),
        .RegDst       (RegDst),
        .MemToReg     (MemToReg),
        .PCSource     (PCSource),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] observed();
        return {state_dbg, ALU1Selector, ALU2Selector, ALUOp, PCWrite, IRWrite, MemRead,
                MemWrite, RegWrite, EPCWrite, RegDst, MemToReg, PCSource};
    endfunction

    function automatic bit fn_legal(logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic [2:0] fn_alu(logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h2A:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Expected {state, outputs} for one cycle spent in state s.
    function automatic logic [21:0] exp_out(state_e s, logic [5:0] fn, logic z);
        logic [1:0] a1 = 0, a2 = 0, pcs = 0;
        logic [2:0] op = 0;
        logic pcw = 0, irw = 0, mr = 0, mw = 0, rw = 0, epcw = 0, rd = 0, m2r = 0;
        case (s)
            ST_FETCH0:   begin mr = 1; a2 = 2'b01; pcw = 1; end
            ST_FETCH1:   begin mr = 1; irw = 1; end
            ST_DECODE:   a2 = 2'b11;
            ST_EXEC_R:   begin a1 = 2'b01; op = fn_alu(fn); end
            ST_WB_R:     begin rd = 1; rw = 1; end
            ST_EXEC_I:   begin a1 = 2'b01; a2 = 2'b10; end
            ST_WB_I:     rw = 1;
            ST_MEM_ADDR: begin a1 = 2'b01; a2 = 2'b10; end
            ST_MEM_RD:   mr = 1;
            ST_MEM_WAIT: mr = 1;
            ST_MEM_WB:   begin m2r = 1; rw = 1; end
            ST_MEM_WR:   mw = 1;
            ST_BRANCH:   begin a1 = 2'b01; op = 3'b001; pcs = 2'b01; pcw = z; end
            ST_JUMP:     begin pcs = 2'b10; pcw = 1; end
            ST_EXC:      begin a2 = 2'b01; op = 3'b001; epcw = 1; pcs = 2'b11; pcw = 1; end
            default:     ;
        endcase
        return {5'(s), a1, a2, op, pcw, irw, mr, mw, rw, epcw, rd, m2r, pcs};
    endfunction

    // Reference: state path of one instruction from FETCH1 through the next FETCH0.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov, input logic z);
        state_e path[$];
        path.push_back(ST_FETCH1);
        path.push_back(ST_DECODE);
        case (op)
            6'h00: begin
                path.push_back(ST_EXEC_R);
                if (!fn_legal(fn) || (ov && (fn == 6'h20 || fn == 6'h22))) path.push_back(ST_EXC);
                else path.push_back(ST_WB_R);
            end
            6'h08: begin
                path.push_back(ST_EXEC_I);
                path.push_back(ov ? ST_EXC : ST_WB_I);
            end
            6'h23: begin
                path.push_back(ST_MEM_ADDR); path.push_back(ST_MEM_RD);
                path.push_back(ST_MEM_WAIT); path.push_back(ST_MEM_WB);
            end
            6'h2B: begin path.push_back(ST_MEM_ADDR); path.push_back(ST_MEM_WR); end
            6'h04: path.push_back(ST_BRANCH);
            6'h02: path.push_back(ST_JUMP);
            default: path.push_back(ST_EXC);
        endcase
        path.push_back(ST_FETCH0);
        exp_q.delete();
        foreach (path[i]) exp_q.push_back(exp_out(path[i], fn, z));
    endtask

    // Driver: starts in FETCH1, records every cycle until FETCH0 is seen again (bounded).
    task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov, input logic z);
        obs_q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            opcode = op;
            funct  = fn;
            if (i == 2) begin
                overflow = ov;
                zero     = z;
            end else begin
                overflow = 1'($urandom_range(0, 1));
                zero     = 1'($urandom_range(0, 1));
            end
            #1;
            obs_q.push_back(observed());
            if (i > 0 && state_dbg == ST_FETCH0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (observed() !== exp_out(ST_RST, 6'h00, 1'b0)) begin
            failures++;
            $display("FAIL reset_state got=%h required=%h", observed(), exp_out(ST_RST, 6'h00, 1'b0));
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (observed() !== exp_out(ST_FETCH0, 6'h00, 1'b0)) begin
            failures++;
            $display("FAIL first_fetch got=%h required=%h", observed(), exp_out(ST_FETCH0, 6'h00, 1'b0));
        end
    endtask

    task automatic test_r_type();
        model_instr(6'h00, 6'h22, 1'b0, 1'b0);
        drive_instr(6'h00, 6'h22, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() - 1 != 4) begin
            failures++;
            $display("FAIL r_type_cpi got=%0d required=4", obs_q.size() - 1);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL r_type_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL r_type_step got=%h required=%h", got, want);
            end
        end
        model_instr(6'h00, 6'h2A, 1'b1, 1'b0);
        drive_instr(6'h00, 6'h2A, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL slt_ovf_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL slt_ovf_step got=%h required=%h", got, want);
            end
        end
    endtask

    task automatic test_mem();
        logic [5:0] ops[2] = '{6'h23, 6'h2B};
        int cpi[2] = '{6, 4};
        for (int k = 0; k < 2; k++) begin
            model_instr(ops[k], 6'h00, 1'b0, 1'b0);
            drive_instr(ops[k], 6'h00, 1'b0, 1'b0);
            checks++;
            if (obs_q.size() - 1 != cpi[k]) begin
                failures++;
                $display("FAIL mem_cpi op=%h got=%0d required=%0d", ops[k], obs_q.size() - 1, cpi[k]);
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL mem_step op=%h got=%h required=%h", ops[k], got, want);
                end
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL mem_len op=%h leftover_got=%0d leftover_required=%0d", ops[k], obs_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops[3] = '{6'h04, 6'h04, 6'h02};
        logic zs[3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            model_instr(ops[k], 6'h00, 1'b0, zs[k]);
            drive_instr(ops[k], 6'h00, 1'b0, zs[k]);
            checks++;
            if (obs_q.size() - 1 != 3) begin
                failures++;
                $display("FAIL br_j_cpi op=%h got=%0d required=3", ops[k], obs_q.size() - 1);
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL br_j_step op=%h zero=%0d got=%h required=%h", ops[k], zs[k], got, want);
                end
            end
        end
    endtask

    task automatic test_exceptions();
        logic [5:0] ops[4] = '{6'h08, 6'h00, 6'h00, 6'h3F};
        logic [5:0] fns[4] = '{6'h00, 6'h20, 6'h13, 6'h20};
        logic ovs[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            model_instr(ops[k], fns[k], ovs[k], 1'b0);
            drive_instr(ops[k], fns[k], ovs[k], 1'b0);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL exc_len case=%0d got=%0d required=%0d", k, obs_q.size(), exp_q.size());
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL exc_step case=%0d got=%h required=%h", k, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h23;
        funct  = 6'h00;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (observed() !== exp_out(ST_MEM_WAIT, 6'h00, 1'b0)) begin
            failures++;
            $display("FAIL mem_wait_before_reset got=%h required=%h", observed(), exp_out(ST_MEM_WAIT, 6'h00, 1'b0));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (observed() !== exp_out(ST_RST, 6'h00, 1'b0)) begin
            failures++;
            $display("FAIL async_reset got=%h required=%h", observed(), exp_out(ST_RST, 6'h00, 1'b0));
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (observed() !== exp_out(ST_FETCH0, 6'h00, 1'b0)) begin
            failures++;
            $display("FAIL refetch_after_reset got=%h required=%h", observed(), exp_out(ST_FETCH0, 6'h00, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [5:0] op_tbl[7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
        logic [5:0] fn_tbl[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [5:0] op, fn;
        logic ov, z;
        for (int n = 0; n < 150; n++) begin
            op = op_tbl[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            fn = fn_tbl[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
            ov = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            model_instr(op, fn, ov, z);
            drive_instr(op, fn, ov, z);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_len n=%0d op=%h fn=%h got=%0d required=%0d", n, op, fn, obs_q.size(), exp_q.size());
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL rand_step n=%0d op=%h fn=%h ov=%0d z=%0d got=%h required=%h",
                             n, op, fn, ov, z, got, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_mem();
        test_branch_jump();
        test_exceptions();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
